// File: rtl/life_controller.sv
// Player-life sequencer: life count, post-loss blink pause, respawn and game-over; frame-timed by startOfFrame.
// Latency: all outputs registered, one cycle after the triggering pulse; no backpressure (pulse inputs are never stalled).
module life_controller #(
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 9,
  parameter int PAUSE_FRAMES = 120,
  parameter int BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       ballLost,
  input  logic       extraLife,
  output logic [3:0] life,
  output logic       lifeVisible,
  output logic       playActive,
  output logic       ballRespawn,
  output logic       gameOver
);

  localparam int FW = $clog2(PAUSE_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam logic [3:0]    INIT_L  = 4'(INIT_LIVES);
  localparam logic [3:0]    MAX_L   = 4'(MAX_LIVES);
  localparam logic [FW-1:0] PAUSE_L = FW'(PAUSE_FRAMES);
  localparam logic [BW-1:0] BLINK_L = BW'(BLINK_FRAMES);

  typedef enum logic [1:0] {IDLE, PLAYING, LOSS_PAUSE, GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic [3:0]    life_q, life_d;
  logic          vis_q, vis_d;
  logic          respawn_q, respawn_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]    life_inc;

  // Extra life saturates at the ceiling; a drop at MAX is silent.
  assign life_inc = (life_q >= MAX_L) ? MAX_L : life_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    life_d      = life_q;
    vis_d       = vis_q;
    respawn_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        vis_d = 1'b1;
        if (startGame) begin
          state_d     = PLAYING;
          life_d      = INIT_L;
          respawn_d   = 1'b1;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
        end
      end
      PLAYING: begin
        if (ballLost) begin
          if (life_q <= 4'd1 && !extraLife) begin
            state_d = GAME_OVER;
            life_d  = 4'd0;
            vis_d   = 1'b1;
          end else begin
            // Loss and award in the same cycle cancel out.
            state_d     = LOSS_PAUSE;
            life_d      = extraLife ? life_q : life_q - 4'd1;
            vis_d       = 1'b0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
          end
        end else if (extraLife) begin
          life_d = life_inc;
        end
      end
      LOSS_PAUSE: begin
        if (extraLife) life_d = life_inc;
        if (startOfFrame) begin
          frame_cnt_d = frame_cnt_q + FW'(1);
          blink_cnt_d = blink_cnt_q + BW'(1);
          if (blink_cnt_d == BLINK_L) begin
            vis_d       = ~vis_q;
            blink_cnt_d = '0;
          end
          if (frame_cnt_d == PAUSE_L) begin
            state_d     = PLAYING;
            vis_d       = 1'b1;
            respawn_d   = 1'b1;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      life_q      <= 4'd0;
      vis_q       <= 1'b1;
      respawn_q   <= 1'b0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      life_q      <= life_d;
      vis_q       <= vis_d;
      respawn_q   <= respawn_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign life        = life_q;
  assign lifeVisible = vis_q;
  assign ballRespawn = respawn_q;
  assign playActive  = (state_q == PLAYING);
  assign gameOver    = (state_q == GAME_OVER);

endmodule

// File: tb/tb_life_controller.sv
// Scoreboard bench for life_controller: driver pushes model predictions, monitor pops and compares each cycle.
module tb_life_controller;
  localparam int INIT  = 3;
  localparam int MAXL  = 9;
  localparam int PAUSE = 120;
  localparam int BLINK = 15;

  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0, startGame = 1'b0, ballLost = 1'b0, extraLife = 1'b0;
  logic [3:0] life;
  logic       lifeVisible, playActive, ballRespawn, gameOver;

  life_controller #(
    .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .PAUSE_FRAMES(PAUSE), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .ballLost(ballLost), .extraLife(extraLife), .life(life), .lifeVisible(lifeVisible),
    .playActive(playActive), .ballRespawn(ballRespawn), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    int life;
    bit vis;
    bit play;
    bit resp;
    bit over;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: game phase, lives, frames elapsed in the current pause.
  int m_mode = M_IDLE;
  int m_life = 0;
  int m_frames = 0;
  bit m_resp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.life = m_life;
    e.vis  = (m_mode == M_PAUSE) ? ((m_frames / BLINK) % 2 == 1) : 1'b1;
    e.play = (m_mode == M_PLAY);
    e.resp = m_resp;
    e.over = (m_mode == M_OVER);
    return e;
  endfunction

  task automatic step(input bit sof, input bit sg, input bit bl, input bit el);
    @(negedge clk);
    startOfFrame = sof; startGame = sg; ballLost = bl; extraLife = el;
    m_resp = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (sg) begin m_mode = M_PLAY; m_life = INIT; m_resp = 1; end
      M_PLAY: begin
        if (bl) begin
          if (m_life - 1 + int'(el) <= 0) begin
            m_mode = M_OVER; m_life = 0;
          end else begin
            m_mode = M_PAUSE; m_life = m_life - 1 + int'(el); m_frames = 0;
          end
        end else if (el && m_life < MAXL) m_life++;
      end
      default: begin
        if (el && m_life < MAXL) m_life++;
        if (sof) begin
          m_frames++;
          if (m_frames == PAUSE) begin m_mode = M_PLAY; m_resp = 1; end
        end
      end
    endcase
    sb.push_back(predict());
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_life"}, int'(life), 0);
    chk({tag, "_vis"}, int'(lifeVisible), 1);
    chk({tag, "_play"}, int'(playActive), 0);
    chk({tag, "_resp"}, int'(ballRespawn), 0);
    chk({tag, "_over"}, int'(gameOver), 0);
  endtask

  // Monitor: every cycle with a pending prediction is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("life", int'(life), e.life);
        chk("lifeVisible", int'(lifeVisible), int'(e.vis));
        chk("playActive", int'(playActive), int'(e.play));
        chk("ballRespawn", int'(ballRespawn), int'(e.resp));
        chk("gameOver", int'(gameOver), int'(e.over));
      end
    end
  end

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    resetN = 1'b1;

    step(0, 0, 1, 1);               // ignored in IDLE
    step(0, 1, 0, 0);               // start: life 3, one respawn
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);               // start ignored while playing
    step(1, 0, 1, 0);               // loss with concurrent frame: pause starts fresh
    frames(PAUSE + 3);              // blink phases, respawn at 120
    step(0, 0, 1, 0);               // life 1
    frames(PAUSE);
    step(0, 0, 1, 0);               // game over
    frames(3);
    step(0, 1, 0, 0);               // restart
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);  // saturate at 9
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);               // restart ignored, still 9
    step(0, 0, 0, 0);
    // Walk life down to 1 with short-circuited pauses.
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      frames(PAUSE);
    end
    step(0, 0, 1, 1);               // loss + award at life 1: pause, life 1
    frames(10);
    step(0, 0, 1, 0);               // ignored in pause
    step(0, 1, 0, 0);               // ignored in pause
    step(1, 0, 0, 1);               // award during pause, frame still counted
    frames(20);

    // Reset between edges in the middle of the pause.
    @(negedge clk);
    startOfFrame = 0; startGame = 0; ballLost = 0; extraLife = 0;
    #2 resetN = 1'b0;
    #1 chk_reset_vals("midreset");
    m_mode = M_IDLE; m_life = 0; m_frames = 0; m_resp = 0;
    @(negedge clk);
    resetN = 1'b1;
    step(1, 0, 1, 1);
    frames(4);                      // stays idle
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Randomised play.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
